// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator:
// FSM state encodings and one-hot {gt,eq,lt} result codes.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [2:0] res_t;

    localparam res_t GT   = 3'b100;
    localparam res_t EQ   = 3'b010;
    localparam res_t LT   = 3'b001;
    localparam res_t NONE = 3'b000;

    // Slice index width; a single-slice operand still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one D-bit operand slice.
module cmp_slice
    import cmp_pkg::*;
#(
    parameter int D = 2
) (
    input  logic [D-1:0] slice_a,
    input  logic [D-1:0] slice_b,
    output logic         slice_gt,
    output logic         slice_eq
);

    assign slice_gt = (slice_a > slice_b);
    assign slice_eq = (slice_a == slice_b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Serial MSB-first magnitude comparator, D bits per cycle with early exit.
// Define SEQ_CMP_SIGNED_EN for two's-complement operands.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int NS = W / D;
    localparam int IW = idx_width(NS);
    localparam logic [IW-1:0] MSB_IDX = IW'(NS - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    res_t          res_q, res_d;

    logic [D-1:0]  sa, sb;
    logic          slice_gt, slice_eq;

    always_comb begin
        sa = a_q[int'(idx_q)*D +: D];
        sb = b_q[int'(idx_q)*D +: D];
`ifdef SEQ_CMP_SIGNED_EN
        // Inverting both sign bits maps two's complement onto unsigned order.
        if (idx_q == MSB_IDX) begin
            sa[D-1] = ~sa[D-1];
            sb[D-1] = ~sb[D-1];
        end
`endif
    end

    cmp_slice #(.D(D)) u_slice (
        .slice_a  (sa),
        .slice_b  (sb),
        .slice_gt (slice_gt),
        .slice_eq (slice_eq)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = MSB_IDX;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!slice_eq) begin
                    res_d   = slice_gt ? GT : LT;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign ready        = (state_q == IDLE);
    assign done         = (state_q == DONE);
    assign {gt, eq, lt} = res_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench: W=8/D=2 directed vectors plus a W/D sweep vs a model.
module tb_seq_mag_comparator;

    typedef struct {
        logic [2:0] res;
        int         due;
    } exp_t;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset, start;
    logic [7:0] a, b;
    logic       ready, done, gt, eq, lt;

    logic        start_s;
    logic [15:0] a_s, b_s;
    logic [2:0]  rdy_s, dn_s;
    logic [2:0]  r0, r1, r2;

    seq_mag_comparator #(.W(8), .D(2)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    seq_mag_comparator #(.W(8), .D(8)) u_w8d8 (
        .clk(clk), .reset(reset), .start(start_s),
        .a(a_s[7:0]), .b(b_s[7:0]),
        .ready(rdy_s[0]), .done(dn_s[0]),
        .gt(r0[2]), .eq(r0[1]), .lt(r0[0])
    );

    seq_mag_comparator #(.W(16), .D(4)) u_w16d4 (
        .clk(clk), .reset(reset), .start(start_s),
        .a(a_s), .b(b_s),
        .ready(rdy_s[1]), .done(dn_s[1]),
        .gt(r1[2]), .eq(r1[1]), .lt(r1[0])
    );

    seq_mag_comparator #(.W(12), .D(3)) u_w12d3 (
        .clk(clk), .reset(reset), .start(start_s),
        .a(a_s[11:0]), .b(b_s[11:0]),
        .ready(rdy_s[2]), .done(dn_s[2]),
        .gt(r2[2]), .eq(r2[1]), .lt(r2[0])
    );

    int asserts = 0;
    int fails   = 0;

    exp_t       q[$];
    logic [2:0] sq0[$], sq1[$], sq2[$];
    logic [2:0] last_res = 3'b000;
    int         last_due = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [2:0] model(logic [15:0] x, logic [15:0] y, int w);
        longint m, sx, sy;
        m  = (longint'(1) << w) - 1;
        sx = longint'(x) & m;
        sy = longint'(y) & m;
`ifdef SEQ_CMP_SIGNED_EN
        if (((sx >> (w - 1)) & 1) != 0) sx = sx - (longint'(1) << w);
        if (((sy >> (w - 1)) & 1) != 0) sy = sy - (longint'(1) << w);
`endif
        if (sx > sy) return R_GT;
        if (sx == sy) return R_EQ;
        return R_LT;
    endfunction

    // Main scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_res = 3'b000;
        end else if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(1'b0));
            end else begin
                e = q.pop_front();
                check("result", 32'({gt, eq, lt}), 32'(e.res));
                check("latency", 32'(cyc), 32'(e.due));
                last_res = e.res;
            end
        end else begin
            check("hold", 32'({gt, eq, lt}), 32'(last_res));
        end
    end

    always @(negedge clk) if (!reset && dn_s[0]) begin
        if (sq0.size() == 0) check("w8d8_unexpected", 32'(1), 32'(0));
        else check("w8d8_result", 32'(r0), 32'(sq0.pop_front()));
    end

    always @(negedge clk) if (!reset && dn_s[1]) begin
        if (sq1.size() == 0) check("w16d4_unexpected", 32'(1), 32'(0));
        else check("w16d4_result", 32'(r1), 32'(sq1.pop_front()));
    end

    always @(negedge clk) if (!reset && dn_s[2]) begin
        if (sq2.size() == 0) check("w12d3_unexpected", 32'(1), 32'(0));
        else check("w12d3_result", 32'(r2), 32'(sq2.pop_front()));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present operands, wait for acceptance, push the expected result.
    task automatic issue(logic [7:0] x, logic [7:0] y, logic [2:0] r,
                         int k, bit keep, bit b2b);
        int n = 0;
        int acc;
        a = x;
        b = y;
        start = 1'b1;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (!ready) check("accept_timeout", 32'(ready), 32'(1'b1));
        @(posedge clk);
        #1;
        acc = cyc;
        if (b2b) check("b2b_accept", 32'(acc), 32'(last_due + 2));
        q.push_back('{res: r, due: acc + k});
        last_due = acc + k;
        #1;
        a = ~x;
        b = ~y;
        if (!keep) start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        start = 1'b0;
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'(0));
        repeat (3) tick();
    endtask

    task automatic sweep(logic [15:0] x, logic [15:0] y);
        int n = 0;
        while (rdy_s != 3'b111 && n < 50) begin
            tick();
            n++;
        end
        if (rdy_s != 3'b111) check("sweep_ready", 32'(rdy_s), 32'(3'b111));
        a_s = x;
        b_s = y;
        start_s = 1'b1;
        sq0.push_back(model(x, y, 8));
        sq1.push_back(model(x, y, 16));
        sq2.push_back(model(x, y, 12));
        tick();
        start_s = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        start_s = 1'b0;
        a_s = '0;
        b_s = '0;
        repeat (3) tick();
        check("rst_done", 32'(done), 32'(0));
        check("rst_res", 32'({gt, eq, lt}), 32'(0));
        check("rst_idle", 32'(ready), 32'(1));
        reset = 1'b0;
        tick();
        check("ready_after_rst", 32'(ready), 32'(1));

`ifdef SEQ_CMP_SIGNED_EN
        issue(8'hA5, 8'h5A, R_LT, 1, 0, 0);
        issue(8'h80, 8'h7F, R_LT, 1, 0, 0);
        issue(8'h01, 8'h81, R_GT, 1, 0, 0);
`else
        issue(8'hA5, 8'h5A, R_GT, 1, 0, 0);
        issue(8'h80, 8'h7F, R_GT, 1, 0, 0);
        issue(8'h01, 8'h81, R_LT, 1, 0, 0);
`endif
        issue(8'h3C, 8'h3C, R_EQ, 4, 0, 0);
        issue(8'h40, 8'h48, R_LT, 3, 0, 0);
        issue(8'hFF, 8'hFE, R_GT, 4, 0, 0);
        drain();

        // Start held high through RUN and DONE: exactly one result.
        issue(8'h12, 8'h13, R_LT, 4, 1, 0);
        drain();
        check("idle_after_held", 32'(ready), 32'(1));

        // Back-to-back with start held continuously.
        issue(8'h00, 8'h00, R_EQ, 4, 1, 0);
        issue(8'hC0, 8'h40, model(16'h00C0, 16'h0040, 8), 1, 1, 1);
        issue(8'h27, 8'h24, R_GT, 4, 1, 1);
        drain();

        // Reset one cycle after start aborts the comparison.
        a = 8'h3C;
        b = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_res", 32'({gt, eq, lt}), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        repeat (6) tick();

        // Reset wins over start on the same edge.
        issue(8'h9A, 8'h9A, R_EQ, 4, 0, 0);
        drain();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("prio_ready", 32'(ready), 32'(1));
        check("prio_res", 32'({gt, eq, lt}), 32'(0));
        repeat (6) tick();

        sweep(16'h0080, 16'h007F);
        sweep(16'h8000, 16'h7FFF);
        sweep(16'h0800, 16'h07FF);
        sweep(16'h1234, 16'h1234);
        for (int i = 0; i < 24; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = (i % 4 == 0) ? x ^ 16'(1 << (i % 16)) : 16'($urandom);
            sweep(x, y);
        end
        n = 0;
        while ((sq0.size() + sq1.size() + sq2.size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        check("sweep_drain", 32'(sq0.size() + sq1.size() + sq2.size()), 32'(0));
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
